// File: rtl/fp_sub_pkg.sv
// Shared widths, limits and FSM state type for the sequential single-precision subtractor.
package fp_sub_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MAN_W  = 24;

    localparam logic [EXP_W-1:0] EXP_MAX     = 8'hFF;
    localparam logic [EXP_W-1:0] ALIGN_CLAMP = 8'd24;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

endpackage

// File: rtl/fp_unpack.sv
// Splits a single-precision word into sign, exponent and 24-bit mantissa with hidden bit.
module fp_unpack
    import fp_sub_pkg::*;
(
    input  logic [31:0]      word_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W-1:0] man_o,
    output logic             is_zero_o
);

    always_comb begin
        sign_o    = word_i[31];
        exp_o     = word_i[30:23];
        is_zero_o = (word_i[30:23] == '0);
        man_o     = {~is_zero_o, word_i[FRAC_W-1:0]};
    end

endmodule

// File: rtl/fp_sequential_subtractor.sv
// Multi-cycle A - B: one-bit-per-cycle alignment and normalization behind valid/ready handshakes.
module fp_sequential_subtractor
    import fp_sub_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        over_flow,
    output logic        under_flow
);

    state_e state_q, state_d;

    logic             sign_q, sign_d;
    logic             sub_q, sub_d;
    logic [EXP_W-1:0] dist_q, dist_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MAN_W-1:0] ml_q, ml_d;
    logic [MAN_W-1:0] ms_q, ms_d;
    logic [MAN_W:0]   sum_q, sum_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             sign_a, sign_b, zero_a, zero_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b, man_a_eff, man_b_eff;
    logic             a_ge_b;
    logic [EXP_W:0]   exp_inc;
    logic             norm_done;

    fp_unpack u_unpack_a (
        .word_i    (inputA),
        .sign_o    (sign_a),
        .exp_o     (exp_a),
        .man_o     (man_a),
        .is_zero_o (zero_a)
    );

    fp_unpack u_unpack_b (
        .word_i    (inputB),
        .sign_o    (sign_b),
        .exp_o     (exp_b),
        .man_o     (man_b),
        .is_zero_o (zero_b)
    );

    // exp==0 operands flush to zero, so their fraction never reaches the adder
    assign man_a_eff = zero_a ? '0 : man_a;
    assign man_b_eff = zero_b ? '0 : man_b;
    assign a_ge_b    = (inputA[30:0] >= inputB[30:0]);
    assign exp_inc   = {1'b0, exp_q} + 9'd1;
    assign norm_done = (sum_q == '0) || sum_q[MAN_W] || sum_q[MAN_W-1] || (exp_q <= 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            dist_q   <= '0;
            exp_q    <= '0;
            ml_q     <= '0;
            ms_q     <= '0;
            sum_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            dist_q   <= dist_d;
            exp_q    <= exp_d;
            ml_q     <= ml_d;
            ms_q     <= ms_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StAlign;
            StAlign: if (dist_q == '0) state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  if (norm_done) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sign_d   = sign_q;
        sub_d    = sub_q;
        dist_d   = dist_q;
        exp_d    = exp_q;
        ml_d     = ml_q;
        ms_d     = ms_q;
        sum_d    = sum_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // B enters with its sign inverted, turning A - B into A + (-B)
                    sub_d = sign_a ^ ~sign_b;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    if (a_ge_b) begin
                        sign_d = sign_a;
                        exp_d  = exp_a;
                        ml_d   = man_a_eff;
                        ms_d   = man_b_eff;
                        dist_d = exp_a - exp_b;
                    end else begin
                        sign_d = ~sign_b;
                        exp_d  = exp_b;
                        ml_d   = man_b_eff;
                        ms_d   = man_a_eff;
                        dist_d = exp_b - exp_a;
                    end
                end
            end
            StAlign: begin
                if (dist_q > ALIGN_CLAMP) begin
                    ms_d   = '0;
                    dist_d = '0;
                end else if (dist_q != '0) begin
                    ms_d   = ms_q >> 1;
                    dist_d = dist_q - 8'd1;
                end
            end
            StAdd: begin
                sum_d = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
            end
            StNorm: begin
                if (sum_q == '0) begin
                    result_d = '0;
                end else if (sum_q[MAN_W]) begin
                    if (exp_inc >= {1'b0, EXP_MAX}) begin
                        ovf_d    = 1'b1;
                        exp_d    = EXP_MAX;
                        result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                    end else begin
                        sum_d    = sum_q >> 1;
                        exp_d    = exp_inc[EXP_W-1:0];
                        result_d = {sign_q, exp_inc[EXP_W-1:0], sum_q[MAN_W-1:1]};
                    end
                end else if (sum_q[MAN_W-1]) begin
                    result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
                end else if (exp_q <= 8'd1) begin
                    unf_d    = 1'b1;
                    result_d = '0;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == StIdle) && rst_n;
        out_valid  = (state_q == StDone);
        result     = result_q;
        over_flow  = ovf_q;
        under_flow = unf_q;
    end

endmodule
